mem_dump_reader: RTL and testbench

- Read-back engine for the processor's data memory: the reader counterpart of the bench-side loader, which writes words through a mem_addr/mem_data_in port.
- On a start pulse it walks a contiguous address range, issues synchronous reads into the data memory read port, and streams each word out on a valid/ready interface.
- Used by benches and the debug path to dump memory after a program halts.

---
 rtl/mem_dump_if.sv | 42 ++++
 rtl/mem_dump_reader.sv | 166 ++++++++++++++++
 tb/tb_mem_dump_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_if.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_dump_if                                                  |
// | Description : Control, data-memory read port and output stream bundle for  |
// |               mem_dump_reader.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_dump_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic [DATA_W-1:0] checksum;

   modport master (
      output start, base_addr, word_count, mem_rd_data, out_ready,
      input  busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data,
             out_addr, out_last, checksum
   );

   modport slave (
      input  start, base_addr, word_count, mem_rd_data, out_ready,
      output busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data,
             out_addr, out_last, checksum
   );
endinterface

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_dump_reader                                              |
// | Description : Walks a data-memory address range and streams each word out  |
// |               on valid/ready. Optional running sum: MEM_DUMP_CHECKSUM_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_dump_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  wire logic  clk,
   input  wire logic  rst,
   mem_dump_if.slave  dump_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t            state_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  issued_q;
   logic              infl_q;
   logic              infl_last_q;
   logic [ADDR_W-1:0] infl_addr_q;

   logic [DATA_W-1:0] fifo_data_q [2];
   logic [ADDR_W-1:0] fifo_addr_q [2];
   logic [1:0]        fifo_last_q;
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        occ_q;
   logic [1:0]        occ_d;

   logic w_push;
   logic w_pop;
   logic w_issue;
   logic w_last_issue;
   logic w_head_last;

   assign w_push       = infl_q;
   assign w_pop        = (occ_q != 2'd0) && dump_if.out_ready;
   assign w_head_last  = fifo_last_q[rd_ptr_q];
   assign w_last_issue = (issued_q == (cnt_q - CNT_W'(1)));

   // The in-flight read is exactly the FIFO write of this cycle, so occ_d is
   // the post-edge occupancy; a new read may only go out if it will have room.
   always_comb begin
      occ_d = occ_q + {1'b0, w_push} - {1'b0, w_pop};
   end

   assign w_issue = (state_q == S_ISSUE) && (occ_d < 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_addr_q   <= '0;
         cnt_q       <= '0;
         issued_q    <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         infl_addr_q <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
         end
         fifo_last_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         occ_q       <= '0;
      end else begin
         if (w_push) begin
            fifo_data_q[wr_ptr_q] <= dump_if.mem_rd_data;
            fifo_addr_q[wr_ptr_q] <= infl_addr_q;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q  <= occ_d;
         infl_q <= w_issue;
         if (w_issue) begin
            infl_addr_q <= rd_addr_q;
            infl_last_q <= w_last_issue;
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            issued_q    <= issued_q + CNT_W'(1);
         end

         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (dump_if.start) begin
                  rd_addr_q <= dump_if.base_addr;
                  cnt_q     <= dump_if.word_count;
                  issued_q  <= '0;
                  if (dump_if.word_count != '0) begin
                     state_q <= S_ISSUE;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (w_issue && w_last_issue) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The last-flagged word leaving the FIFO implies nothing is left behind it.
               if (w_pop && w_head_last) begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign dump_if.busy        = busy_q;
   assign dump_if.done        = done_q;
   assign dump_if.mem_rd_en   = w_issue;
   assign dump_if.mem_rd_addr = rd_addr_q;
   assign dump_if.out_valid   = (occ_q != 2'd0);
   assign dump_if.out_data    = fifo_data_q[rd_ptr_q];
   assign dump_if.out_addr    = fifo_addr_q[rd_ptr_q];
   assign dump_if.out_last    = w_head_last;

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else if ((state_q == S_IDLE) && dump_if.start) begin
         csum_q <= '0;
      end else if (w_pop) begin
         csum_q <= csum_q + fifo_data_q[rd_ptr_q];
      end
   end

   assign dump_if.checksum = csum_q;
`else
   assign dump_if.checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_dump_reader                                           |
// | Description : Directed self-checking bench for mem_dump_reader.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_dump_reader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [DATA_W-1:0] mem [32];

   mem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .dump_if (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read data memory model
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      32'(bus.busy),        0);
      check({tag, "_done"},      32'(bus.done),        0);
      check({tag, "_rd_en"},     32'(bus.mem_rd_en),   0);
      check({tag, "_rd_addr"},   32'(bus.mem_rd_addr), 0);
      check({tag, "_valid"},     32'(bus.out_valid),   0);
      check({tag, "_data"},      bus.out_data,         0);
      check({tag, "_addr"},      32'(bus.out_addr),    0);
      check({tag, "_last"},      32'(bus.out_last),    0);
      check({tag, "_checksum"},  bus.checksum,         0);
   endtask

   // Runs one dump and checks every observable against the memory model.
   // abort_hs > 0 leaves right after that many handshakes have been seen.
   task automatic run_dump(input int base, input int count, input bit bp,
                           input int sb_cycle, input int abort_hs);
      int issued   = 0;
      int accepted = 0;
      int first_v  = -1;
      int done_c   = -1;
      int done_cnt = 0;
      int exp_done_c;
      logic [31:0] sum = 0;
      logic [31:0] exp_cs;
      bit hs;
      bit prev_stall = 0;
      logic [31:0] p_data = 0;
      logic [31:0] p_addr = 0;
      logic [31:0] p_last = 0;

      @(negedge clk);
      bus.start      = 1'b1;
      bus.base_addr  = ADDR_W'(base);
      bus.word_count = CNT_W'(count);
      bus.out_ready  = 1'b1;
      exp_done_c     = (count == 0) ? 1 : -1;

      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         bus.start = (c == sb_cycle);
         if (c == sb_cycle) begin
            bus.base_addr  = 5'd20;
            bus.word_count = 6'd3;
         end
         bus.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         hs = bus.out_valid && bus.out_ready;
         if (c == 1) check("busy_after_start", 32'(bus.busy), 32'(count != 0));
         if (bus.out_valid && first_v < 0) first_v = c;
         if (bus.mem_rd_en) begin
            check("rd_room", 32'((issued - accepted - int'(hs)) < 2), 1);
            check("rd_addr", 32'(bus.mem_rd_addr), 32'((base + issued) % 32));
            issued++;
         end
         if (prev_stall) begin
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_data",  bus.out_data,       p_data);
            check("stall_addr",  32'(bus.out_addr),  p_addr);
            check("stall_last",  32'(bus.out_last),  p_last);
         end
         if (bus.done) begin
            done_cnt++;
            if (done_c < 0) done_c = c;
            check("done_cycle",   32'(c),        32'(exp_done_c));
            check("busy_at_done", 32'(bus.busy), 0);
`ifdef MEM_DUMP_CHECKSUM_EN
            exp_cs = sum;
`else
            exp_cs = 0;
`endif
            check("checksum", bus.checksum, exp_cs);
         end
         if (hs) begin
            check("out_data", bus.out_data, mem[(base + accepted) % 32]);
            check("out_addr", 32'(bus.out_addr), 32'((base + accepted) % 32));
            check("out_last", 32'(bus.out_last), 32'(accepted == count - 1));
            sum = sum + bus.out_data;
            if (accepted == count - 1) exp_done_c = c + 1;
            accepted++;
            if (accepted == abort_hs) return;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         p_data     = bus.out_data;
         p_addr     = 32'(bus.out_addr);
         p_last     = 32'(bus.out_last);
         if (done_c > 0 && c >= done_c + 3) break;
      end

      check("completed",   32'(done_c > 0), 1);
      check("word_total",  32'(accepted),   32'(count));
      check("read_total",  32'(issued),     32'(count));
      check("done_pulses", 32'(done_cnt),   1);
      check("first_valid", 32'(first_v),    (count == 0) ? 32'hFFFF_FFFF : 32'd3);
   endtask

   initial begin
      int ref_vals [10];
      n_checks = 0;
      n_fail   = 0;
      ref_vals = '{4, 2, 9, 0, 3, 3, 7, 10, 5, 8};
      for (int i = 0; i < 32; i++) mem[i] = 32'(1000 + i);
      for (int i = 0; i < 10; i++) mem[i + 1] = 32'(ref_vals[i]);

      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      bus.out_ready  = 1'b0;
      bus.mem_rd_data = '0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Basic dump with a second start pulse while busy
      run_dump(1, 10, 1'b0, 5, 0);
`ifdef MEM_DUMP_CHECKSUM_EN
      check("basic_checksum", bus.checksum, 51);
`else
      check("basic_checksum", bus.checksum, 0);
`endif

      run_dump(1, 10, 1'b1, 0, 0);
      run_dump(30, 4, 1'b0, 0, 0);
      run_dump(0, 0, 1'b0, 0, 0);
      run_dump(5, 40, 1'b1, 0, 0);

      // Reset after the third handshake
      run_dump(1, 10, 1'b0, 0, 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("post_reset_valid", 32'(bus.out_valid), 0);
         check("post_reset_done",  32'(bus.done),      0);
         check("post_reset_rd_en", 32'(bus.mem_rd_en), 0);
      end
      run_dump(1, 2, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
